// File: rtl/dco_freq_lock_ctrl.sv
// rtl/dco_freq_lock_ctrl.sv - frequency-lock SAR controller for a ring DCO
//
// Purpose:
//   Drives the ring DCO enable (dco_en) and delay-select (alpha) inputs.
//   For each trial alpha it waits for the DCO to settle, then counts DCO
//   rising edges over a fixed window of reference clocks. Alpha is searched
//   MSB first for the code whose count is closest to, but not below, the
//   programmed target.
//
// Optional feature (macro DCO_TRACK_EN):
//   When defined, the LOCKED condition keeps re-measuring the DCO. After each
//   window alpha is nudged by one code to follow drift: down when the count is
//   below target, up when it exceeds target by more than TRACK_TOL.
//   When undefined, LOCKED is static.
//
// Ports:
//   clk         in   reference clock (must exceed 2x the DCO frequency)
//   rst_n       in   asynchronous active-low reset
//   start       in   1-cycle pulse, begins a lock sequence (ignored while busy)
//   stop        in   level, aborts and powers down the DCO (beats start)
//   target_cnt  in   desired edge count per window, sampled on accepted start
//   dco_clk_in  in   DCO output, asynchronous to clk
//   dco_en      out  DCO enable
//   alpha       out  DCO delay select
//   busy        out  search in progress
//   locked      out  search complete, alpha final
//   err         out  target unreachable even with the fastest code
//   meas_cnt    out  count from the last completed window

`timescale 1ns/1ps

module dco_freq_lock_ctrl #(
  parameter int ALPHA_W    = 3,
  parameter int CNT_W      = 10,
  parameter int WIN_CYC    = 256,
  parameter int SETTLE_CYC = 16,
  parameter int TRACK_TOL  = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               stop,
  input  logic [CNT_W-1:0]   target_cnt,
  input  logic               dco_clk_in,
  output logic               dco_en,
  output logic [ALPHA_W-1:0] alpha,
  output logic               busy,
  output logic               locked,
  output logic               err,
  output logic [CNT_W-1:0]   meas_cnt
);

`ifdef DCO_TRACK_EN
  localparam bit TRACK_EN = 1'b1;
`else
  localparam bit TRACK_EN = 1'b0;
`endif

  localparam int TMR_MAX = (WIN_CYC > SETTLE_CYC) ? WIN_CYC : SETTLE_CYC;
  localparam int TMR_W   = $clog2(TMR_MAX) + 1;
  localparam int IDX_W   = (ALPHA_W > 1) ? $clog2(ALPHA_W) : 1;

  localparam logic [ALPHA_W-1:0] ALPHA_MSB  = ALPHA_W'(1 << (ALPHA_W - 1));
  localparam logic [TMR_W-1:0]   SETTLE_END = TMR_W'(SETTLE_CYC - 1);
  localparam logic [TMR_W-1:0]   WIN_END    = TMR_W'(WIN_CYC - 1);
  localparam logic [CNT_W:0]     TOL        = (CNT_W + 1)'(TRACK_TOL);
  localparam logic [IDX_W-1:0]   IDX_TOP    = IDX_W'(ALPHA_W - 1);

  typedef enum logic [2:0] {
    IDLE,
    SETTLE,
    MEASURE,
    DECIDE,
    FINAL_SETTLE,
    FINAL_MEAS,
    LOCKED
  } state_t;

  state_t state, state_n;

  logic               sync1, sync2, sync3;
  logic               edge_pulse;
  logic [TMR_W-1:0]   tmr;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic [CNT_W-1:0]   tgt;
  logic [IDX_W-1:0]   idx;
  logic [ALPHA_W-1:0] alpha_dec, alpha_trk;
  logic               settle_done, win_done;
  logic               start_ok;
  logic               err_nxt;
  // Set while the tracking loop reuses FINAL_SETTLE/FINAL_MEAS after lock.
  logic               track_q;

  // Rising edge of the synchronised DCO clock (sync2 is the resolved sample).
  assign edge_pulse = sync2 & ~sync3;

  // Saturating edge count including the current cycle's edge.
  assign cnt_nxt = (edge_pulse && (cnt != '1)) ? cnt + 1'b1 : cnt;

  assign settle_done = (tmr == SETTLE_END);
  assign win_done    = (tmr == WIN_END);

  assign start_ok = start & ~stop &
                    ((state == IDLE) | (state == LOCKED) | track_q);

  assign err_nxt = (alpha == '0) && (cnt_nxt < tgt);

  // SAR decision: higher alpha is slower, so a count below target means the
  // trial bit made the DCO too slow and must be dropped.
  always_comb begin
    alpha_dec = alpha;
    if (cnt < tgt) begin
      alpha_dec[idx] = 1'b0;
    end
    if (idx != '0) begin
      alpha_dec[idx - 1'b1] = 1'b1;
    end
  end

  // Tracking step: one code per window, with a dead-band above target.
  always_comb begin
    alpha_trk = alpha;
    if (cnt_nxt < tgt) begin
      if (alpha != '0) begin
        alpha_trk = alpha - 1'b1;
      end
    end else if ({1'b0, cnt_nxt} > ({1'b0, tgt} + TOL)) begin
      if (alpha != '1) begin
        alpha_trk = alpha + 1'b1;
      end
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Next-state logic
  always_comb begin
    state_n = state;
    case (state)
      IDLE:         state_n = IDLE;
      SETTLE:       if (settle_done) state_n = MEASURE;
      MEASURE:      if (win_done) state_n = DECIDE;
      DECIDE:       state_n = (idx != '0) ? SETTLE : FINAL_SETTLE;
      FINAL_SETTLE: if (settle_done) state_n = FINAL_MEAS;
      FINAL_MEAS:   if (win_done) state_n = TRACK_EN ? FINAL_SETTLE : LOCKED;
      LOCKED:       state_n = LOCKED;
      default:      state_n = IDLE;
    endcase
    if (start_ok) begin
      state_n = SETTLE;
    end
    if (stop) begin
      state_n = IDLE;
    end
  end

  // Output logic
  always_comb begin
    dco_en = (state != IDLE);
    busy   = !track_q && (state != IDLE) && (state != LOCKED);
    locked = track_q || (state == LOCKED);
  end

  // Datapath: synchroniser, timers, counter, search registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1    <= 1'b0;
      sync2    <= 1'b0;
      sync3    <= 1'b0;
      tmr      <= '0;
      cnt      <= '0;
      tgt      <= '0;
      idx      <= '0;
      alpha    <= '0;
      err      <= 1'b0;
      meas_cnt <= '0;
      track_q  <= 1'b0;
    end else begin
      sync1 <= dco_clk_in;
      sync2 <= sync1;
      sync3 <= sync2;

      // Phase timer restarts on every state change and idles when parked.
      if (state_n != state) begin
        tmr <= '0;
      end else if ((state != IDLE) && (state != LOCKED)) begin
        tmr <= tmr + 1'b1;
      end

      if (stop) begin
        err     <= 1'b0;
        track_q <= 1'b0;
      end else if (start_ok) begin
        tgt     <= target_cnt;
        idx     <= IDX_TOP;
        alpha   <= ALPHA_MSB;
        err     <= 1'b0;
        track_q <= 1'b0;
      end else begin
        case (state)
          SETTLE, FINAL_SETTLE: begin
            if (settle_done) begin
              cnt <= '0;
            end
          end
          MEASURE: begin
            cnt <= cnt_nxt;
          end
          DECIDE: begin
            meas_cnt <= cnt;
            alpha    <= alpha_dec;
            if (idx != '0) begin
              idx <= idx - 1'b1;
            end
          end
          FINAL_MEAS: begin
            cnt <= cnt_nxt;
            if (win_done) begin
              meas_cnt <= cnt_nxt;
              err      <= err_nxt;
              if (TRACK_EN) begin
                track_q <= 1'b1;
                alpha   <= alpha_trk;
              end
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_dco_freq_lock_ctrl.sv
// tb/tb_dco_freq_lock_ctrl.sv - directed bench for dco_freq_lock_ctrl

`timescale 1ns/1ps

module tb_dco_freq_lock_ctrl;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       stop;
  logic [9:0] target_cnt;
  logic       dco_clk_in;
  logic       dco_en;
  logic [2:0] alpha;
  logic       busy;
  logic       locked;
  logic       err;
  logic [9:0] meas_cnt;

  int tests = 0;
  int fails = 0;
  int shift = 0;

  dco_freq_lock_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .stop       (stop),
    .target_cnt (target_cnt),
    .dco_clk_in (dco_clk_in),
    .dco_en     (dco_en),
    .alpha      (alpha),
    .busy       (busy),
    .locked     (locked),
    .err        (err),
    .meas_cnt   (meas_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Behavioural ring DCO: period 40 + 4*alpha (+shift) ns while enabled.
  initial begin
    dco_clk_in = 1'b0;
    forever begin
      if (dco_en) begin
        #((40 + 4 * int'(alpha) + shift) / 2);
        dco_clk_in = ~dco_clk_in;
      end else begin
        dco_clk_in = 1'b0;
        #1;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Leaves the caller at the first negedge after the sampling posedge.
  task automatic pulse_start(input logic [9:0] t);
    target_cnt = t;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_locked(input string tag, input int max_cyc);
    for (int i = 0; i < max_cyc; i++) begin
      if (locked) break;
      @(negedge clk);
    end
    check(tag, locked, 1);
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    stop = 1'b0;
    target_cnt = '0;
    repeat (3) @(negedge clk);

    check("rst_dco_en", dco_en, 0);
    check("rst_alpha", alpha, 0);
    check("rst_busy", busy, 0);
    check("rst_locked", locked, 0);
    check("rst_err", err, 0);
    check("rst_meas", meas_cnt, 0);

    rst_n = 1'b1;
    @(negedge clk);

    // stop beats start in IDLE
    stop = 1'b1;
    start = 1'b1;
    target_cnt = 10'd47;
    @(negedge clk);
    start = 1'b0;
    stop = 1'b0;
    check("prio_busy", busy, 0);
    check("prio_dco_en", dco_en, 0);

    // Test 1: target 47, exact latency 4*(16+256)+3 cycles
    pulse_start(10'd47);
    check("t1_busy0", busy, 1);
    check("t1_dco_en", dco_en, 1);
    check("t1_alpha_msb", alpha, 4);
    repeat (1090) @(negedge clk);
    check("t1_not_yet_locked", locked, 0);
    check("t1_still_busy", busy, 1);
    @(negedge clk);
    check("t1_locked", locked, 1);
    check("t1_busy_done", busy, 0);
    check("t1_alpha", alpha, 3);
    check("t1_err", err, 0);
    check("t1_meas_range", (meas_cnt >= 48 && meas_cnt <= 50), 1);

    // Test 2: target 70 unreachable
    pulse_start(10'd70);
    wait_locked("t2_lock", 1200);
    check("t2_alpha", alpha, 0);
    check("t2_err", err, 1);
    check("t2_meas_range", (meas_cnt >= 63 && meas_cnt <= 65), 1);

    // stop from LOCKED clears err, keeps alpha and meas_cnt
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    check("stopl_err", err, 0);
    check("stopl_locked", locked, 0);
    check("stopl_dco_en", dco_en, 0);
    check("stopl_meas_kept", (meas_cnt >= 63 && meas_cnt <= 65), 1);

    // Test 3: target 30 -> slowest code
    pulse_start(10'd30);
    wait_locked("t3_lock", 1200);
    check("t3_alpha", alpha, 7);
    check("t3_err", err, 0);
    check("t3_meas_range", (meas_cnt >= 36 && meas_cnt <= 39), 1);

    // Test 4: stop mid-MEASURE of step 2, then relock
    pulse_start(10'd47);
    repeat (389) @(negedge clk);
    check("t4_mid_busy", busy, 1);
    check("t4_mid_alpha", alpha, 2);
    stop = 1'b1;
    @(negedge clk);
    check("t4_stop_dco_en", dco_en, 0);
    check("t4_stop_busy", busy, 0);
    check("t4_stop_locked", locked, 0);
    check("t4_stop_alpha_kept", alpha, 2);
    stop = 1'b0;
    @(negedge clk);
    pulse_start(10'd47);
    wait_locked("t4_relock", 1200);
    check("t4_relock_alpha", alpha, 3);

    // Test 5a: second start while busy is ignored
    pulse_start(10'd47);
    repeat (500) @(negedge clk);
    pulse_start(10'd70);
    check("t5_ign_busy", busy, 1);
    wait_locked("t5_ign_lock", 1200);
    check("t5_ign_alpha", alpha, 3);
    check("t5_ign_err", err, 0);

    // Test 5b: asynchronous reset mid-search
    pulse_start(10'd47);
    repeat (300) @(negedge clk);
    check("t5_pre_meas_nz", (meas_cnt != 0), 1);
    #2 rst_n = 1'b0;
    #1;
    check("t5_rst_dco_en", dco_en, 0);
    check("t5_rst_alpha", alpha, 0);
    check("t5_rst_busy", busy, 0);
    check("t5_rst_locked", locked, 0);
    check("t5_rst_err", err, 0);
    check("t5_rst_meas", meas_cnt, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check("t5_post_idle_busy", busy, 0);
    check("t5_post_idle_dco_en", dco_en, 0);

`ifdef DCO_TRACK_EN
    // Test 6: tracking follows a slowed DCO down to alpha 1
    pulse_start(10'd47);
    wait_locked("t6_lock", 1200);
    check("t6_lock_alpha", alpha, 3);
    shift = 8;
    for (int i = 0; i < 3 * 273 + 20; i++) begin
      if (alpha == 3'd1) break;
      @(negedge clk);
    end
    check("t6_track_alpha", alpha, 1);
    check("t6_track_locked", locked, 1);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
